// File: rtl/tetris_pkg.sv
// Shared Tetris playfield constants and the line-clear FSM state encoding.
package tetris_pkg;

  localparam int ROWS      = 16;
  localparam int COLS      = 10;
  localparam int GRID_W    = ROWS * COLS;
  localparam int ROW_IDX_W = $clog2(ROWS);
  localparam int LINES_W   = $clog2(ROWS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_SHIFT,
    ST_FINISH
  } lce_state_e;

endpackage

// File: rtl/line_clear_engine_row_full_check.sv
// Combinational row selector: picks one COLS-wide row out of the grid and reports
// whether every cell in it is occupied.
module row_full_check
  import tetris_pkg::*;
(
  input  logic [GRID_W-1:0]    grid_i,
  input  logic [ROW_IDX_W-1:0] row_i,
  output logic                 full_o
);

  logic [COLS-1:0] row_bits;

  always_comb begin
    row_bits = grid_i[row_i*COLS +: COLS];
    full_o   = &row_bits;
  end

endmodule

// File: rtl/line_clear_engine.sv
// Row-collapse stage: scans the landed grid bottom to top, removes full rows one at a
// time by shifting everything above down a row, then publishes the result and counts.
module line_clear_engine
  import tetris_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               FCLK,
  input  logic               RST_IN,
  input  logic               START,
  input  logic [GRID_W-1:0]  GRID_IN,
  output logic               BUSY,
  output logic               DONE,
  output logic [GRID_W-1:0]  GRID_OUT,
  output logic [LINES_W-1:0] LINES_CLEARED,
  output logic [CNT_W-1:0]   TOTAL_LINES
);

  localparam int SUM_W = CNT_W + 1;

  lce_state_e           state_q;
  logic [GRID_W-1:0]    work_q;
  logic [ROW_IDX_W-1:0] row_q;
  logic [ROW_IDX_W-1:0] shift_q;
  logic [LINES_W-1:0]   count_q;
  logic                 busy_q;
  logic                 done_q;
  logic [GRID_W-1:0]    grid_out_q;
  logic [LINES_W-1:0]   lines_q;
  logic [CNT_W-1:0]     total_q;

  logic                 row_full;
  logic [GRID_W-1:0]    work_d;
  logic [SUM_W-1:0]     total_sum;

  row_full_check u_row_full_check (
    .grid_i (work_q),
    .row_i  (row_q),
    .full_o (row_full)
  );

  // One shift step: row k takes row k-1; at k==0 the top row is refilled with empties.
  always_comb begin
    work_d = work_q;
    for (int i = ROWS - 1; i > 0; i--) begin
      if (ROW_IDX_W'(i) == shift_q) begin
        work_d[i*COLS +: COLS] = work_q[(i-1)*COLS +: COLS];
      end
    end
    if (shift_q == '0) begin
      work_d[0 +: COLS] = '0;
    end
  end

  assign total_sum = {1'b0, total_q} + SUM_W'(count_q);

  // Outputs are loaded on the SCAN->FINISH transition so they are valid alongside DONE.
  always_ff @(posedge FCLK or negedge RST_IN) begin
    if (!RST_IN) begin
      state_q    <= ST_IDLE;
      work_q     <= '0;
      row_q      <= '0;
      shift_q    <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      grid_out_q <= '0;
      lines_q    <= '0;
      total_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            work_q  <= GRID_IN;
            row_q   <= ROW_IDX_W'(ROWS - 1);
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (row_full) begin
            shift_q <= row_q;
            state_q <= ST_SHIFT;
          end else if (row_q == '0) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            grid_out_q <= work_q;
            lines_q    <= count_q;
            total_q    <= total_sum[CNT_W] ? '1 : total_sum[CNT_W-1:0];
            state_q    <= ST_FINISH;
          end else begin
            row_q <= row_q - 1'b1;
          end
        end
        ST_SHIFT: begin
          work_q <= work_d;
          if (shift_q == '0) begin
            count_q <= count_q + 1'b1;
            state_q <= ST_SCAN;
          end else begin
            shift_q <= shift_q - 1'b1;
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign GRID_OUT      = grid_out_q;
  assign LINES_CLEARED = lines_q;
  assign TOTAL_LINES   = total_q;

endmodule

// File: tb/tb_line_clear_engine.sv
// Self-checking bench for line_clear_engine: directed scenarios plus random grids
// compared against a row-list model of the collapse.
module tb_line_clear_engine;
  import tetris_pkg::*;

  localparam int CNT_W = 16;

  logic               FCLK;
  logic               RST_IN;
  logic               START;
  logic [GRID_W-1:0]  GRID_IN;
  logic               BUSY;
  logic               DONE;
  logic [GRID_W-1:0]  GRID_OUT;
  logic [LINES_W-1:0] LINES_CLEARED;
  logic [CNT_W-1:0]   TOTAL_LINES;

  int checks;
  int errors;

  int                 obsDoneCyc;
  int                 obsDoneCount;
  int                 obsBusyCount;
  int                 obsBusyFirst;
  int                 obsBusyLast;
  logic [GRID_W-1:0]  obsGrid;
  logic [LINES_W-1:0] obsLines;
  logic [CNT_W-1:0]   obsTotal;

  line_clear_engine #(.CNT_W(CNT_W)) dut (
    .FCLK          (FCLK),
    .RST_IN        (RST_IN),
    .START         (START),
    .GRID_IN       (GRID_IN),
    .BUSY          (BUSY),
    .DONE          (DONE),
    .GRID_OUT      (GRID_OUT),
    .LINES_CLEARED (LINES_CLEARED),
    .TOTAL_LINES   (TOTAL_LINES)
  );

  initial FCLK = 1'b0;
  always #5 FCLK = ~FCLK;

  // Reference: keep non-full rows in order, pack them at the bottom. A full row at
  // original index j is removed while sitting at j + (full rows below it).
  task automatic modelOp(input logic [GRID_W-1:0] g, output logic [GRID_W-1:0] og,
                         output int lines, output int doneCyc);
    logic [COLS-1:0] kept[$];
    logic [COLS-1:0] row;
    int below;
    int sumR;
    below = 0;
    sumR  = 0;
    for (int j = ROWS - 1; j >= 0; j--) begin
      row = g[j*COLS +: COLS];
      if (&row) begin
        sumR  += j + below + 1;
        below += 1;
      end else begin
        kept.push_back(row);
      end
    end
    og = '0;
    for (int i = 0; i < kept.size(); i++) og[(ROWS-1-i)*COLS +: COLS] = kept[i];
    lines   = below;
    doneCyc = 1 + ROWS + below + sumR;
  endtask

  task automatic applyReset();
    @(negedge FCLK);
    RST_IN = 1'b0;
    @(negedge FCLK);
    RST_IN = 1'b1;
  endtask

  // Runs one operation with START accepted at cycle 0 and records what the DUT showed.
  task automatic applyStimulus(input logic [GRID_W-1:0] g, input int repA, input int repB);
    int cyc;
    int tail;
    @(negedge FCLK);
    GRID_IN = g;
    START   = 1'b1;
    obsDoneCyc   = -1;
    obsDoneCount = 0;
    obsBusyCount = 0;
    obsBusyFirst = -1;
    obsBusyLast  = -1;
    obsGrid      = 'x;
    obsLines     = 'x;
    obsTotal     = 'x;
    cyc  = 0;
    tail = 0;
    while (cyc < 2000 && tail < 20) begin
      @(negedge FCLK);
      cyc++;
      if (BUSY === 1'b1) begin
        obsBusyCount++;
        if (obsBusyFirst < 0) obsBusyFirst = cyc;
        obsBusyLast = cyc;
      end
      if (DONE === 1'b1) begin
        obsDoneCount++;
        if (obsDoneCyc < 0) begin
          obsDoneCyc = cyc;
          obsGrid    = GRID_OUT;
          obsLines   = LINES_CLEARED;
          obsTotal   = TOTAL_LINES;
        end
      end
      if (obsDoneCyc >= 0) tail++;
      START   = (cyc == repA) || (cyc == repB);
      GRID_IN = {$urandom, $urandom, $urandom, $urandom, $urandom};
    end
    START = 1'b0;
  endtask

  task automatic test_reset();
    RST_IN = 1'b0;
    #1;
    checks++; if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", DONE); end
    checks++; if (GRID_OUT !== '0) begin errors++; $display("[TB] FAIL reset_grid: got %h expected 0", GRID_OUT); end
    checks++; if (LINES_CLEARED !== '0) begin errors++; $display("[TB] FAIL reset_lines: got %0d expected 0", LINES_CLEARED); end
    checks++; if (TOTAL_LINES !== '0) begin errors++; $display("[TB] FAIL reset_total: got %0d expected 0", TOTAL_LINES); end
    @(negedge FCLK);
    RST_IN = 1'b1;
  endtask

  task automatic test_empty(input logic [CNT_W-1:0] expTotal);
    applyStimulus('0, -1, -1);
    checks++; if (obsDoneCyc != 17) begin errors++; $display("[TB] FAIL empty_done_cycle: got %0d expected 17", obsDoneCyc); end
    checks++; if (obsBusyFirst != 1 || obsBusyLast != 16 || obsBusyCount != 16) begin
      errors++; $display("[TB] FAIL empty_busy: got first %0d last %0d count %0d expected 1 16 16", obsBusyFirst, obsBusyLast, obsBusyCount);
    end
    checks++; if (obsDoneCount != 1) begin errors++; $display("[TB] FAIL empty_done_count: got %0d expected 1", obsDoneCount); end
    checks++; if (obsLines !== 5'd0) begin errors++; $display("[TB] FAIL empty_lines: got %0d expected 0", obsLines); end
    checks++; if (obsGrid !== '0) begin errors++; $display("[TB] FAIL empty_grid: got %h expected 0", obsGrid); end
    checks++; if (obsTotal !== expTotal) begin errors++; $display("[TB] FAIL empty_total: got %0d expected %0d", obsTotal, expTotal); end
  endtask

  task automatic test_single_clear();
    logic [GRID_W-1:0] g;
    logic [GRID_W-1:0] exp;
    g = '0;
    g[159:150] = '1;
    g[140] = 1'b1;
    exp = '0;
    exp[150] = 1'b1;
    applyStimulus(g, -1, -1);
    checks++; if (obsDoneCyc != 34) begin errors++; $display("[TB] FAIL single_done_cycle: got %0d expected 34", obsDoneCyc); end
    checks++; if (obsLines !== 5'd1) begin errors++; $display("[TB] FAIL single_lines: got %0d expected 1", obsLines); end
    checks++; if (obsGrid !== exp) begin errors++; $display("[TB] FAIL single_grid: got %h expected %h", obsGrid, exp); end
    checks++; if (obsTotal !== 16'd1) begin errors++; $display("[TB] FAIL single_total: got %0d expected 1", obsTotal); end
    checks++; if (GRID_OUT !== exp) begin errors++; $display("[TB] FAIL single_grid_hold: got %h expected %h", GRID_OUT, exp); end
  endtask

  task automatic test_double_clear();
    logic [GRID_W-1:0] g;
    logic [GRID_W-1:0] exp;
    applyReset();
    g = '0;
    g[139:130] = '1;
    g[159:150] = '1;
    g[145] = 1'b1;
    exp = '0;
    exp[155] = 1'b1;
    applyStimulus(g, -1, -1);
    checks++; if (obsDoneCyc != 50) begin errors++; $display("[TB] FAIL double_done_cycle: got %0d expected 50", obsDoneCyc); end
    checks++; if (obsLines !== 5'd2) begin errors++; $display("[TB] FAIL double_lines: got %0d expected 2", obsLines); end
    checks++; if (obsGrid !== exp) begin errors++; $display("[TB] FAIL double_grid: got %h expected %h", obsGrid, exp); end
    checks++; if (obsTotal !== 16'd2) begin errors++; $display("[TB] FAIL double_total: got %0d expected 2", obsTotal); end
  endtask

  task automatic test_full_grid();
    applyReset();
    applyStimulus('1, -1, -1);
    checks++; if (obsDoneCyc != 289) begin errors++; $display("[TB] FAIL full_done_cycle: got %0d expected 289", obsDoneCyc); end
    checks++; if (obsLines !== 5'd16) begin errors++; $display("[TB] FAIL full_lines: got %0d expected 16", obsLines); end
    checks++; if (obsGrid !== '0) begin errors++; $display("[TB] FAIL full_grid: got %h expected 0", obsGrid); end
    checks++; if (obsTotal !== 16'd16) begin errors++; $display("[TB] FAIL full_total1: got %0d expected 16", obsTotal); end
    applyStimulus('1, -1, -1);
    checks++; if (obsTotal !== 16'd32) begin errors++; $display("[TB] FAIL full_total2: got %0d expected 32", obsTotal); end
  endtask

  task automatic test_back_to_back();
    logic [GRID_W-1:0] g;
    logic [GRID_W-1:0] exp;
    g = '0;
    g[159:150] = '1;
    g[140] = 1'b1;
    exp = '0;
    exp[150] = 1'b1;
    applyStimulus(g, 3, 17);
    checks++; if (obsDoneCyc != 34) begin errors++; $display("[TB] FAIL repulse_done_cycle: got %0d expected 34", obsDoneCyc); end
    checks++; if (obsDoneCount != 1) begin errors++; $display("[TB] FAIL repulse_done_count: got %0d expected 1", obsDoneCount); end
    checks++; if (obsGrid !== exp) begin errors++; $display("[TB] FAIL repulse_grid: got %h expected %h", obsGrid, exp); end
    checks++; if (obsTotal !== 16'd33) begin errors++; $display("[TB] FAIL repulse_total: got %0d expected 33", obsTotal); end
  endtask

  task automatic test_random();
    logic [GRID_W-1:0] g;
    logic [GRID_W-1:0] expGrid;
    logic [COLS-1:0]   row;
    logic [CNT_W-1:0]  expTotal;
    int expLines;
    int expDone;
    applyReset();
    expTotal = '0;
    for (int it = 0; it < 10; it++) begin
      for (int r = 0; r < ROWS; r++) begin
        row = COLS'($urandom);
        if ($urandom_range(0, 2) == 0) row = '1;
        else if (&row) row[$urandom_range(0, COLS-1)] = 1'b0;
        g[r*COLS +: COLS] = row;
      end
      modelOp(g, expGrid, expLines, expDone);
      expTotal = expTotal + CNT_W'(expLines);
      applyStimulus(g, -1, -1);
      checks++; if (obsDoneCyc != expDone) begin errors++; $display("[TB] FAIL rand%0d_done_cycle: got %0d expected %0d", it, obsDoneCyc, expDone); end
      checks++; if (obsGrid !== expGrid) begin errors++; $display("[TB] FAIL rand%0d_grid: got %h expected %h", it, obsGrid, expGrid); end
      checks++; if (obsLines !== LINES_W'(expLines)) begin errors++; $display("[TB] FAIL rand%0d_lines: got %0d expected %0d", it, obsLines, expLines); end
      checks++; if (obsTotal !== expTotal) begin errors++; $display("[TB] FAIL rand%0d_total: got %0d expected %0d", it, obsTotal, expTotal); end
      checks++; if (obsBusyFirst != 1 || obsBusyCount != expDone - 1) begin
        errors++; $display("[TB] FAIL rand%0d_busy: got first %0d count %0d expected 1 %0d", it, obsBusyFirst, obsBusyCount, expDone - 1);
      end
      checks++; if (obsDoneCount != 1) begin errors++; $display("[TB] FAIL rand%0d_done_count: got %0d expected 1", it, obsDoneCount); end
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [GRID_W-1:0] g;
    g = '0;
    g[159:150] = '1;
    g[140] = 1'b1;
    @(negedge FCLK);
    GRID_IN = g;
    START   = 1'b1;
    @(negedge FCLK);
    START = 1'b0;
    repeat (4) @(negedge FCLK);
    checks++; if (TOTAL_LINES === '0) begin errors++; $display("[TB] FAIL midshift_pre_total: got 0 expected nonzero"); end
    #2;
    RST_IN = 1'b0;
    #1;
    checks++; if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL midshift_busy: got %b expected 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("[TB] FAIL midshift_done: got %b expected 0", DONE); end
    checks++; if (GRID_OUT !== '0) begin errors++; $display("[TB] FAIL midshift_grid: got %h expected 0", GRID_OUT); end
    checks++; if (TOTAL_LINES !== '0) begin errors++; $display("[TB] FAIL midshift_total: got %0d expected 0", TOTAL_LINES); end
    @(negedge FCLK);
    RST_IN = 1'b1;
    test_empty('0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    RST_IN  = 1'b1;
    START   = 1'b0;
    GRID_IN = '0;
    #3;
    test_reset();
    test_empty('0);
    test_single_clear();
    test_double_clear();
    test_full_grid();
    test_back_to_back();
    test_random();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
